// File: rtl/nasti_mem_wr_slave_if.sv
// NASTI write-path bundle (AW/W/B channels) shared by the write slave and its master.
interface nasti_mem_wr_slave_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) ();
    // Write address channel
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic                    aw_ready;

    // Write data channel
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    // Write response channel
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready
    );
endinterface

// File: rtl/nasti_mem_wr_slave.sv
// NASTI write slave: one burst at a time, each W beat becomes a single-cycle
// write on a synchronous SRAM port, one B response per burst.
module nasti_mem_wr_slave #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    nasti_mem_wr_slave_if.slave                             bus,
    output logic                                            mem_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]      mem_addr,
    output logic [DATA_WIDTH/8-1:0]                         mem_be,
    output logic [DATA_WIDTH-1:0]                           mem_wdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_SHIFT);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [ID_WIDTH-1:0]     id_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              len_reg;
    logic [2:0]              size_reg;
    logic [1:0]              burst_reg;
    logic [7:0]              cnt_reg;
    // Configuration errors suppress every write of the burst; framing (w_last)
    // errors only affect the response, so they are tracked separately.
    logic                    cfg_err_reg;
    logic                    last_err_reg;

    logic                    in_data;
    logic                    in_resp;
    logic                    beat;
    logic                    final_beat;
    logic                    aw_cfg_err;
    logic [ADDR_WIDTH-1:0]   beat_bytes;
    logic [ADDR_WIDTH-1:0]   size_mask;
    logic [ADDR_WIDTH-1:0]   aligned_next;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // All outputs are forced low while rst is asserted, whatever the state.
    assign in_data    = (state_reg == DATA) && !rst;
    assign in_resp    = (state_reg == RESP) && !rst;
    assign beat       = (state_reg == DATA) && bus.w_valid;
    assign final_beat = (cnt_reg == len_reg);

    // Validate the AW request at capture time.
    always_comb begin
        aw_cfg_err = 1'b0;
        if (bus.aw_burst == BURST_RSVD) begin
            aw_cfg_err = 1'b1;
        end
        if (bus.aw_size > MAX_SIZE) begin
            aw_cfg_err = 1'b1;
        end
        if (bus.aw_burst == BURST_WRAP &&
            !(bus.aw_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            aw_cfg_err = 1'b1;
        end
    end

    // Address of the next beat for the captured burst type.
    always_comb begin
        beat_bytes   = ADDR_WIDTH'(1) << size_reg;
        size_mask    = beat_bytes - ADDR_WIDTH'(1);
        // Only the first INCR/WRAP beat may be unaligned; every step re-aligns.
        aligned_next = (addr_reg & ~size_mask) + beat_bytes;
        // Wrap block is (len+1) beats; len is a power of two minus one when legal.
        wrap_mask    = ((ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg) - ADDR_WIDTH'(1);
        addr_next    = addr_reg;
        case (burst_reg)
            BURST_FIXED: addr_next = addr_reg;
            BURST_INCR:  addr_next = aligned_next;
            BURST_WRAP:  addr_next = (addr_reg & ~wrap_mask) | (aligned_next & wrap_mask);
            default:     addr_next = addr_reg;
        endcase
    end

    // Burst sequencing: capture AW, count W beats, hold B until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            cnt_reg      <= '0;
            cfg_err_reg  <= 1'b0;
            last_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.aw_valid) begin
                        id_reg       <= bus.aw_id;
                        addr_reg     <= bus.aw_addr;
                        len_reg      <= bus.aw_len;
                        size_reg     <= bus.aw_size;
                        burst_reg    <= bus.aw_burst;
                        cnt_reg      <= '0;
                        cfg_err_reg  <= aw_cfg_err;
                        last_err_reg <= 1'b0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        addr_reg <= addr_next;
                        cnt_reg  <= cnt_reg + 8'd1;
                        // w_last must be set exactly on the final counted beat.
                        if (bus.w_last != final_beat) begin
                            last_err_reg <= 1'b1;
                        end
                        if (final_beat) begin
                            state_reg <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.b_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Channel handshakes and response fields decoded from the state.
    assign bus.aw_ready = (state_reg == IDLE) && !rst;
    assign bus.w_ready  = in_data;
    assign bus.b_valid  = in_resp;
    assign bus.b_id     = in_resp ? id_reg : '0;
    assign bus.b_resp   = !in_resp ? RESP_OKAY :
                          (cfg_err_reg || last_err_reg) ? RESP_SLVERR : RESP_OKAY;
    assign bus.b_user   = '0;

    // SRAM port is a zero-latency pass-through of the current beat.
    assign mem_we   = in_data && bus.w_valid && !cfg_err_reg;
    assign mem_addr = in_data ? addr_reg[ADDR_WIDTH-1:BYTE_SHIFT] : '0;

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_byte_lane
            assign mem_be[gi]           = in_data && bus.w_strb[gi];
            assign mem_wdata[gi*8 +: 8] = in_data ? bus.w_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_nasti_mem_wr_slave.sv
// Directed bench for nasti_mem_wr_slave: the stimulus process pushes expected
// SRAM writes and B responses into queues; a monitor on the falling edge pops
// and compares whenever the DUT presents a write or completes a B handshake.
module tb_nasti_mem_wr_slave;
    localparam int ID_WIDTH   = 1;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 64;
    localparam int USER_WIDTH = 1;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic       id;
        logic [1:0] resp;
    } b_t;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    wr_t wq[$];
    b_t  bq[$];

    // Monitor control flags, written only by the stimulus process.
    logic rst_chk   = 1'b0;
    logic rdy_chk   = 1'b0;
    logic nob_chk   = 1'b0;
    logic final_chk = 1'b0;

    nasti_mem_wr_slave_if #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)
    ) bus ();

    nasti_mem_wr_slave #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        wr_t e;
        b_t  r;
        if (rst_chk) begin
            chk("rst_handshakes", {61'd0, bus.aw_ready, bus.w_ready, bus.b_valid}, 64'd0);
            chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
            chk("rst_mem_addr_be", {43'd0, mem_addr, mem_be}, 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
            chk("rst_b_fields", {61'd0, bus.b_id, bus.b_resp}, 64'd0);
        end
        if (rdy_chk) begin
            chk("post_rst_aw_ready", {63'd0, bus.aw_ready}, 64'd1);
        end
        if (nob_chk) begin
            chk("no_b_after_rst", {63'd0, bus.b_valid}, 64'd0);
        end
        if (!rst && mem_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_addr", {51'd0, mem_addr}, 64'h1FFF_FFFF);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", {51'd0, mem_addr}, {51'd0, e.addr});
                chk("wr_be", {56'd0, mem_be}, {56'd0, e.be});
                chk("wr_data", mem_wdata, e.data);
            end
        end
        if (!rst && bus.b_valid && bus.b_ready) begin
            if (bq.size() == 0) begin
                chk("unexpected_b_resp", {62'd0, bus.b_resp}, 64'hFF);
            end else begin
                r = bq.pop_front();
                chk("b_id", {63'd0, bus.b_id}, {63'd0, r.id});
                chk("b_resp", {62'd0, bus.b_resp}, {62'd0, r.resp});
                chk("b_user", {63'd0, bus.b_user}, 64'd0);
                chk("aw_ready_during_b", {63'd0, bus.aw_ready}, 64'd0);
            end
        end
        if (final_chk) begin
            chk("wr_queue_drained", 64'(wq.size()), 64'd0);
            chk("b_queue_drained", 64'(bq.size()), 64'd0);
        end
    end

    task automatic exp_wr(input logic [12:0] a, input logic [7:0] be, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.be   = be;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic exp_b(input logic id, input logic [1:0] resp);
        b_t r;
        r.id   = id;
        r.resp = resp;
        bq.push_back(r);
    endtask

    task automatic do_aw(input logic id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.aw_id    = id;
        bus.aw_addr  = addr;
        bus.aw_len   = len;
        bus.aw_size  = size;
        bus.aw_burst = burst;
        bus.aw_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL aw_timeout: aw_ready never seen, expected within 200 cycles");
                $fatal(1, "aw handshake timeout");
            end
        end while (!bus.aw_ready);
        @(posedge clk);
        #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n;
        bus.w_data  = data;
        bus.w_strb  = strb;
        bus.w_last  = last;
        bus.w_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL w_timeout: w_ready never seen, expected within 200 cycles");
                $fatal(1, "w handshake timeout");
            end
        end while (!bus.w_ready);
        @(posedge clk);
        #1;
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (wq.size() != 0 || bq.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL drain_timeout: %0d writes / %0d responses still pending, expected 0",
                         wq.size(), bq.size());
                $fatal(1, "drain timeout");
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.aw_id    = '0;
        bus.aw_addr  = '0;
        bus.aw_len   = '0;
        bus.aw_size  = '0;
        bus.aw_burst = '0;
        bus.aw_valid = 1'b0;
        bus.w_data   = '0;
        bus.w_strb   = '0;
        bus.w_last   = 1'b0;
        bus.w_valid  = 1'b0;
        bus.b_ready  = 1'b1;

        // Reset state: every output low while rst is held, aw_ready right after.
        #1;
        rst_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        rst_chk = 1'b0;
        rdy_chk = 1'b1;
        @(posedge clk);
        #1;
        rdy_chk = 1'b0;

        // INCR 0x100 len=3 size=3 -> words 0x20..0x23, OKAY id 1.
        for (int i = 0; i < 4; i++) exp_wr(13'h20 + 13'(i), 8'hFF, 64'h1111_0000_0000_0000 + 64'(i));
        exp_b(1'b1, 2'd0);
        do_aw(1'b1, 16'h0100, 8'd3, 3'd3, 2'd1);
        for (int i = 0; i < 4; i++) do_w(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, i == 3);
        drain();

        // WRAP 0x38 len=3 size=3 -> words 7,4,5,6, OKAY id 0.
        exp_wr(13'h7, 8'hFF, 64'h2222_0000_0000_0000);
        exp_wr(13'h4, 8'hFF, 64'h2222_0000_0000_0001);
        exp_wr(13'h5, 8'hFF, 64'h2222_0000_0000_0002);
        exp_wr(13'h6, 8'hFF, 64'h2222_0000_0000_0003);
        exp_b(1'b0, 2'd0);
        do_aw(1'b0, 16'h0038, 8'd3, 3'd3, 2'd2);
        for (int i = 0; i < 4; i++) do_w(64'h2222_0000_0000_0000 + 64'(i), 8'hFF, i == 3);
        drain();

        // FIXED 0x10 len=2 with strobes 0x0F, 0xF0, 0xFF -> word 2 three times.
        exp_wr(13'h2, 8'h0F, 64'h3333_0000_0000_0000);
        exp_wr(13'h2, 8'hF0, 64'h3333_0000_0000_0001);
        exp_wr(13'h2, 8'hFF, 64'h3333_0000_0000_0002);
        exp_b(1'b1, 2'd0);
        do_aw(1'b1, 16'h0010, 8'd2, 3'd3, 2'd0);
        do_w(64'h3333_0000_0000_0000, 8'h0F, 1'b0);
        do_w(64'h3333_0000_0000_0001, 8'hF0, 1'b0);
        do_w(64'h3333_0000_0000_0002, 8'hFF, 1'b1);
        drain();

        // Reserved burst type: beats accepted, no writes, SLVERR.
        exp_b(1'b1, 2'd2);
        do_aw(1'b1, 16'h0040, 8'd1, 3'd3, 2'd3);
        do_w(64'h4444_0000_0000_0000, 8'hFF, 1'b0);
        do_w(64'h4444_0000_0000_0001, 8'hFF, 1'b1);
        drain();

        // Oversized beat (size 4 on a 64-bit bus): no writes, SLVERR.
        exp_b(1'b0, 2'd2);
        do_aw(1'b0, 16'h0080, 8'd1, 3'd4, 2'd1);
        do_w(64'h5555_0000_0000_0000, 8'hFF, 1'b0);
        do_w(64'h5555_0000_0000_0001, 8'hFF, 1'b1);
        drain();

        // WRAP with illegal len=2: no writes, SLVERR.
        exp_b(1'b1, 2'd2);
        do_aw(1'b1, 16'h0020, 8'd2, 3'd3, 2'd2);
        for (int i = 0; i < 3; i++) do_w(64'h6666_0000_0000_0000 + 64'(i), 8'hFF, i == 2);
        drain();

        // INCR len=3 with an early w_last on beat 1: all four writes, SLVERR.
        for (int i = 0; i < 4; i++) exp_wr(13'h40 + 13'(i), 8'hFF, 64'h7777_0000_0000_0000 + 64'(i));
        exp_b(1'b0, 2'd2);
        do_aw(1'b0, 16'h0200, 8'd3, 3'd3, 2'd1);
        for (int i = 0; i < 4; i++) do_w(64'h7777_0000_0000_0000 + 64'(i), 8'hFF, i == 1 || i == 3);
        drain();

        // Following burst is clean: len=0 INCR to 0x08 -> word 1, OKAY.
        exp_wr(13'h1, 8'hA5, 64'h8888_0000_0000_0000);
        exp_b(1'b1, 2'd0);
        do_aw(1'b1, 16'h0008, 8'd0, 3'd3, 2'd1);
        do_w(64'h8888_0000_0000_0000, 8'hA5, 1'b1);
        drain();

        // Unaligned INCR, size 2 at 0x0E: 0x0E, 0x10, 0x14 -> words 1, 2, 2.
        exp_wr(13'h1, 8'hC0, 64'h9999_0000_0000_0000);
        exp_wr(13'h2, 8'h0F, 64'h9999_0000_0000_0001);
        exp_wr(13'h2, 8'hF0, 64'h9999_0000_0000_0002);
        exp_b(1'b0, 2'd0);
        do_aw(1'b0, 16'h000E, 8'd2, 3'd2, 2'd1);
        do_w(64'h9999_0000_0000_0000, 8'hC0, 1'b0);
        do_w(64'h9999_0000_0000_0001, 8'h0F, 1'b0);
        do_w(64'h9999_0000_0000_0002, 8'hF0, 1'b1);
        drain();

        // Reset during beat 2 of a len=7 burst with b_ready low: burst abandoned.
        bus.b_ready = 1'b0;
        exp_wr(13'h0, 8'hFF, 64'hAAAA_0000_0000_0000);
        exp_wr(13'h1, 8'hFF, 64'hAAAA_0000_0000_0001);
        do_aw(1'b1, 16'h0000, 8'd7, 3'd3, 2'd1);
        do_w(64'hAAAA_0000_0000_0000, 8'hFF, 1'b0);
        do_w(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
        rst         = 1'b1;
        rst_chk     = 1'b1;
        bus.w_data  = 64'hAAAA_0000_0000_0002;
        bus.w_strb  = 8'hFF;
        bus.w_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.w_valid = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rst_chk = 1'b0;
        rdy_chk = 1'b1;
        nob_chk = 1'b1;
        @(posedge clk);
        #1;
        rdy_chk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        nob_chk     = 1'b0;
        bus.b_ready = 1'b1;

        // Normal operation resumes after the abandoned burst.
        exp_wr(13'h10, 8'hFF, 64'hBBBB_0000_0000_0000);
        exp_wr(13'h11, 8'hFF, 64'hBBBB_0000_0000_0001);
        exp_b(1'b0, 2'd0);
        do_aw(1'b0, 16'h0080, 8'd1, 3'd3, 2'd1);
        do_w(64'hBBBB_0000_0000_0000, 8'hFF, 1'b0);
        do_w(64'hBBBB_0000_0000_0001, 8'hFF, 1'b1);
        drain();

        // Nothing left pending and no stray writes or responses.
        repeat (3) @(posedge clk);
        #1;
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
